// File: rtl/debounce_filter_if.sv
// rtl/debounce_filter_if.sv - debounce filter signal bundle; edge pulses present with DEBOUNCE_EDGE_OUT_EN
interface debounce_filter_if;
  logic din;
  logic dout;
  logic busy;
`ifdef DEBOUNCE_EDGE_OUT_EN
  logic rise_pulse;
  logic fall_pulse;

  modport master (output din, input dout, input busy, input rise_pulse, input fall_pulse);
  modport slave  (input din, output dout, output busy, output rise_pulse, output fall_pulse);
`else
  modport master (output din, input dout, input busy);
  modport slave  (input din, output dout, output busy);
`endif
endinterface

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - synchronizer plus qualification FSM that debounces din; DEBOUNCE_EDGE_OUT_EN adds rise/fall pulses
module debounce_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input logic              clk,
  input logic              rst,
  debounce_filter_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   sync_q;

  assign sync_q  = sync_chain_q[SYNC_STAGES-1];
  // Saturating increment keeps the counter from wrapping whatever the count reaches.
  assign cnt_inc = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], bus.din};
    state_d      = state_q;
    cnt_d        = cnt_q;
    case (state_q)
      STABLE_LO: if (sync_q) begin
        if (STABLE_CYCLES == 1) state_d = STABLE_HI;
        else begin
          state_d = CHK_HI;
          cnt_d   = CW'(1);
        end
      end
      CHK_HI: if (sync_q) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_DONE) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end
      end else begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
      STABLE_HI: if (!sync_q) begin
        if (STABLE_CYCLES == 1) state_d = STABLE_LO;
        else begin
          state_d = CHK_LO;
          cnt_d   = CW'(1);
        end
      end
      CHK_LO: if (!sync_q) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_DONE) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      end else begin
        state_d = STABLE_HI;
        cnt_d   = '0;
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they land in flops on the same edge.
    dout_d = (state_d == STABLE_HI) || (state_d == CHK_LO);
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STABLE_LO;
      sync_chain_q <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_chain_q <= sync_chain_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;

`ifdef DEBOUNCE_EDGE_OUT_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
`endif
endmodule

// File: tb/tb_debounce_filter.sv
// tb/tb_debounce_filter.sv - scoreboard bench for debounce_filter with a sampled-history reference model
module tb_debounce_filter;
  localparam int SYNC   = 2;
  localparam int STABLE = 3;
  localparam int DEPTH  = SYNC + STABLE + 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  debounce_filter_if dif ();

  debounce_filter #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: dout flips once the last STABLE synchronized samples all differ from it.
  bit         hist[$];
  bit         m_dout;
  logic [3:0] exp_q[$];

  always @(posedge clk) begin
    bit toggle, nd, inp;
    if (rst) begin
      hist.delete();
      repeat (DEPTH) hist.push_back(1'b0);
      m_dout = 1'b0;
      exp_q.push_back(4'b0000);
    end else begin
      hist.push_back(dif.din);
      void'(hist.pop_front());
      toggle = 1'b1;
      for (int j = 0; j < STABLE; j++)
        if (hist[hist.size() - 1 - SYNC - j] == m_dout) toggle = 1'b0;
      nd  = toggle ? ~m_dout : m_dout;
      inp = hist[hist.size() - 1 - SYNC];
      exp_q.push_back({nd, inp != nd, nd & ~m_dout, ~nd & m_dout});
      m_dout = nd;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dout", 32'(dif.dout), 32'(e[3]));
      check("busy", 32'(dif.busy), 32'(e[2]));
`ifdef DEBOUNCE_EDGE_OUT_EN
      check("rise_pulse", 32'(dif.rise_pulse), 32'(e[1]));
      check("fall_pulse", 32'(dif.fall_pulse), 32'(e[0]));
`endif
    end
  end

  task automatic measure(input logic val, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    @(negedge clk) dif.din = val;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (dif.dout === val) seen = 1;
    end
    check(name, 32'(n), 32'(SYNC + STABLE));
  endtask

  initial begin
    int mode, len, d1, d2;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    dif.din  = 1'b0;

    #5;
    repeat (6) #10 dif.din = ~dif.din;
    rst = 1'b0;
    dif.din = 1'b0;
    @(posedge clk) #1;
    check("reset_dout", 32'(dif.dout), 32'd0);
    check("reset_busy", 32'(dif.busy), 32'd0);
    repeat (4) @(negedge clk);

    measure(1'b1, "rise_latency");
    repeat (6) @(negedge clk);
    measure(1'b0, "fall_latency");
    repeat (4) @(negedge clk);

    @(negedge clk) #5 dif.din = 1'b1;
    #3 dif.din = 1'b0;
    @(negedge clk) #10 dif.din = 1'b1;
    #15 dif.din = 1'b0;
    @(negedge clk) #10 dif.din = 1'b1;
    #60 dif.din = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_dout", 32'(dif.dout), 32'd0);

    @(negedge clk) dif.din = 1'b1;
    @(negedge clk);
    @(negedge clk) dif.din = 1'b0;
    measure(1'b1, "abort_latency");
    repeat (4) @(negedge clk);
    measure(1'b0, "fall2_latency");
    repeat (4) @(negedge clk);

    @(negedge clk) dif.din = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rst_mid_dout", 32'(dif.dout), 32'd0);
    check("rst_mid_busy", 32'(dif.busy), 32'd0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end else if (mode <= 2) begin
        d1 = int'($urandom_range(2, 8));
        d2 = ($urandom_range(0, 1) == 0) ? int'($urandom_range(3, 10)) : int'($urandom_range(20, 30));
        @(negedge clk) #(d1) dif.din = ~dif.din;
        #(d2) dif.din = ~dif.din;
      end else begin
        len = int'($urandom_range(1, 6));
        @(negedge clk) dif.din = 1'($urandom_range(0, 1));
        repeat (len - 1) @(negedge clk);
      end
    end

    @(negedge clk) dif.din = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
